axi_rd_responder: RTL

- AXI4 read-channel slave (responder) backed by a 64-bit word memory array.
- Answers AR/R bursts from read masters such as the instruction-cache line fill; it is the memory end of that interface.
- Used as the simulation and FPGA instruction/data store. Has a backdoor write port for program preload.
- Handles one outstanding transaction. Supports FIXED, INCR and WRAP bursts with a programmable response latency.

---
 rtl/axi_rd_responder.sv | 103 ++++++++++
 1 files changed

// File: rtl/axi_rd_responder.sv
// axi_rd_responder: single-outstanding AXI4 read slave over a 64-bit word memory.
// Supports FIXED/INCR/WRAP bursts, programmable first-beat latency and a backdoor preload port.
module axi_rd_responder #(
    parameter int ID_WIDTH = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ID_WIDTH-1:0]          s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
    input  logic [7:0]                   s_axi_arlen,
    input  logic [2:0]                   s_axi_arsize,
    input  logic [1:0]                   s_axi_arburst,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [ID_WIDTH-1:0]          s_axi_rid,
    output logic [DATA_WIDTH-1:0]        s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rlast,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    input  logic                         bd_we,
    input  logic [$clog2(MEM_WORDS)-1:0] bd_word,
    input  logic [DATA_WIDTH-1:0]        bd_data
);
    localparam int WW = ADDR_WIDTH - 3;
    localparam int IW = $clog2(MEM_WORDS);
    localparam int LW = $clog2(LATENCY + 1);
    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;
    state_t state, nxt;
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic [ID_WIDTH-1:0] id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0] len_q, beat;
    logic [1:0] burst_q;
    logic err_q, ar_hs, r_hs, last, bad, in_range, ok;
    logic [LW-1:0] lat;
    logic [WW-1:0] word, off, lenw, next_word;
    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign r_hs = s_axi_rvalid && s_axi_rready;
    assign last = beat == len_q;
    assign bad = s_axi_arsize != 3'd3 || s_axi_arburst == 2'd3 ||
                 (s_axi_arburst == 2'd2 && !(s_axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
    assign word = addr_q[ADDR_WIDTH-1:3];
    assign lenw = WW'(len_q);
    // WRAP keeps the upper bits and increments only inside the (len+1)-word aligned block
    assign next_word = burst_q == 2'd0 ? word :
                       burst_q == 2'd2 ? (word & ~lenw) | ((word + 1'b1) & lenw) : word + 1'b1;
    // Unsigned offset from the base: words below the base wrap to huge values and fall out of range
    assign off = word - BASE_ADDR[ADDR_WIDTH-1:3];
    assign in_range = (off >> IW) == '0;
    always_ff @(posedge clk) begin
        if (bd_we) mem[bd_word] <= bd_data;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = state == IDLE ? (ar_hs ? WAIT : IDLE) :
              state == WAIT ? (lat == '0 ? BURST : WAIT) :
              (r_hs && last ? IDLE : BURST);
    end
    always_comb begin
        s_axi_arready = state == IDLE && !reset;
        s_axi_rvalid = state == BURST;
        s_axi_rlast = s_axi_rvalid && last;
        s_axi_rid = id_q;
        ok = s_axi_rvalid && !err_q && in_range;
        s_axi_rresp = s_axi_rvalid && !ok ? 2'd2 : 2'd0;
        s_axi_rdata = ok ? mem[off[IW-1:0]] : '0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_q <= '0;
            addr_q <= '0;
            len_q <= '0;
            beat <= '0;
            burst_q <= '0;
            err_q <= 1'b0;
            lat <= '0;
        end else begin
            if (ar_hs) begin
                id_q <= s_axi_arid;
                addr_q <= s_axi_araddr;
                len_q <= s_axi_arlen;
                burst_q <= s_axi_arburst;
                err_q <= bad;
                beat <= '0;
                lat <= LW'(LATENCY - 1);
            end
            if (state == WAIT && lat != '0) lat <= lat - 1'b1;
            if (r_hs) begin
                beat <= beat + 8'd1;
                addr_q <= {next_word, addr_q[2:0]};
            end
        end
    end
endmodule
